// File: rtl/bcd_count_display.sv
// Four-digit BCD up/down counter stepped by a synchronized clk_N edge,
// with a multiplexed active-low seven-segment display driver.
module bcd_count_display #(
  parameter int SCAN_N = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_N,
  input  logic [2:0]  SW,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  AN,
  output logic [6:0]  SEG
);

  localparam int SCAN_W = (SCAN_N > 1) ? $clog2(SCAN_N) : 1;

  logic s1, s2, s3;
  logic step;
  logic run, down, clear;
  logic [15:0] inc_val, dec_val;
  logic        inc_c, dec_b;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_last;
  logic [1:0]        idx;
  logic [3:0]        digit;
  logic [6:0]        seg_next;

  assign run   = SW[0];
  assign down  = SW[1];
  assign clear = SW[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_N;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3;

  // Ripple decimal carry: a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    inc_val = count;
    inc_c   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_c) begin
        if (count[i*4 +: 4] >= 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
        end else begin
          inc_val[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dec_val = count;
    dec_b   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dec_b) begin
        if (count[i*4 +: 4] == 4'd0) begin
          dec_val[i*4 +: 4] = 4'd9;
        end else begin
          dec_val[i*4 +: 4] = count[i*4 +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= 16'h0000;
      wrap  <= 1'b0;
    end else if (step && run) begin
      count <= down ? dec_val : inc_val;
      wrap  <= down ? dec_b : inc_c;
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign scan_last = (scan_cnt == SCAN_W'(SCAN_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_last) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign digit = count[idx*4 +: 4];

  always_comb begin
    seg_next = 7'b1111111;
    unique case (digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
  end

  // AN and SEG come from the same index in the same register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN  <= 4'b1110;
      SEG <= 7'b1000000;
    end else begin
      AN  <= ~(4'b0001 << idx);
      SEG <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_count_display.sv
// Scoreboard bench for bcd_count_display: stimulus queues expected count
// changes, a negedge monitor matches every observed change against them.
module tb_bcd_count_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_N = 1'b0;
  logic [2:0]  SW = 3'b000;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  bcd_count_display #(.SCAN_N(4)) dut (
    .clk(clk), .rst(rst), .clk_N(clk_N), .SW(SW),
    .count(count), .wrap(wrap), .AN(AN), .SEG(SEG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic        w;
    int          cy;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int mval = 0;
  bit mon_on = 0;
  logic [15:0] prev = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (count !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_change", {16'h0, count}, {16'h0, prev});
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("count", {16'h0, count}, {16'h0, e.c});
          chk("wrap", {31'h0, wrap}, {31'h0, e.w});
          chk("latency", cyc, e.cy);
        end
      end else if (wrap !== 1'b0) begin
        chk("wrap_idle", {31'h0, wrap}, 32'h0);
      end
    end
    prev = count;
  end

  // One clk_N period; counts if expect is set, model follows SW[1].
  task automatic step_edge(input bit expect_chg);
    exp_t e;
    bit w;
    @(negedge clk);
    clk_N = 1'b1;
    if (expect_chg) begin
      w = 0;
      if (SW[1]) begin
        w = (mval == 0);
        mval = (mval == 0) ? 9999 : mval - 1;
      end else begin
        w = (mval == 9999);
        mval = (mval + 1) % 10000;
      end
      e.c = to_bcd(mval);
      e.w = w;
      e.cy = cyc + 3;
      q.push_back(e);
    end
    repeat (3) @(negedge clk);
    clk_N = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    if (mon_on && mval != 0) begin
      e.c = 16'h0;
      e.w = 1'b0;
      e.cy = cyc + 1;
      q.push_back(e);
    end
    mval = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] an_exp [4];
  logic [6:0] seg_exp [4];

  initial begin
    logic [3:0] prev_an;
    bit found;
    int c0;
    exp_t e;

    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101;
    an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    seg_exp[0] = 7'b1111000; seg_exp[1] = 7'b0010010;
    seg_exp[2] = 7'b0011001; seg_exp[3] = 7'b1000000;

    do_reset();
    chk("rst_count", {16'h0, count}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    chk("rst_an", {28'h0, AN}, 32'he);
    chk("rst_seg", {25'h0, SEG}, 32'h40);
    prev = count;
    mon_on = 1;

    SW = 3'b001;
    for (int i = 0; i < 12; i++) step_edge(1);
    chk("up12", {16'h0, count}, 32'h0012);

    do_reset();
    SW = 3'b011;
    step_edge(1);
    chk("under", {16'h0, count}, 32'h9999);
    SW = 3'b001;
    step_edge(1);
    chk("over", {16'h0, count}, 32'h0000);

    SW = 3'b011;
    step_edge(1);
    step_edge(1);
    chk("pre9998", {16'h0, count}, 32'h9998);
    SW = 3'b001;
    step_edge(1);
    step_edge(1);
    chk("roll", {16'h0, count}, 32'h0000);

    for (int i = 0; i < 457; i++) step_edge(1);
    chk("to0457", {16'h0, count}, 32'h0457);
    SW = 3'b000;
    for (int i = 0; i < 5; i++) step_edge(0);
    chk("hold", {16'h0, count}, 32'h0457);

    found = 0;
    prev_an = AN;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'b0111 && AN == 4'b1110) found = 1;
      else prev_an = AN;
    end
    chk("scan_found", {31'h0, found}, 32'h1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i != 0) @(negedge clk);
        chk($sformatf("an_%0d", i), {28'h0, AN}, {28'h0, an_exp[i/4]});
        chk($sformatf("seg_%0d", i), {25'h0, SEG}, {25'h0, seg_exp[i/4]});
      end
    end

    SW = 3'b001;
    @(negedge clk);
    clk_N = 1'b1;
    c0 = cyc;
    repeat (2) @(negedge clk);
    SW = 3'b101;
    e.c = 16'h0;
    e.w = 1'b0;
    e.cy = c0 + 3;
    q.push_back(e);
    mval = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_wrap", {31'h0, wrap}, 32'h0);
    end
    chk("clr_count", {16'h0, count}, 32'h0);
    clk_N = 1'b0;
    SW = 3'b001;
    repeat (4) @(negedge clk);
    chk("clr_held", {16'h0, count}, 32'h0);

    for (int i = 0; i < 321; i++) step_edge(1);
    chk("to0321", {16'h0, count}, 32'h0321);
    repeat (2) @(negedge clk);
    do_reset();
    chk("mrst_count", {16'h0, count}, 32'h0);
    chk("mrst_an", {28'h0, AN}, 32'he);
    chk("mrst_seg", {25'h0, SEG}, 32'h40);
    chk("mrst_wrap", {31'h0, wrap}, 32'h0);

    repeat (6) @(negedge clk);
    chk("queue_empty", q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
